// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and state encodings for the two-master dmem arbiter.
// Imported by the arbiter top and its round-robin picker.
package dmem_arbiter_pkg;

  localparam int D_XLEN = 32;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie, the master that was not granted last wins.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = req0_i & (~req1_i | last_i);
  assign gnt1_o = req1_i & (~req0_i | ~last_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between the datapath (master 0) and a loader/debug port (master 1).
// Round-robin arbitration with locked bursts capped at MAX_BURST beats while the other master waits.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN      = D_XLEN,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            lock0,
  input  logic            lock1,
  input  logic [XLEN-1:0] addr0,
  input  logic [XLEN-1:0] addr1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic [XLEN-1:0] wmask0,
  input  logic [XLEN-1:0] wmask1,
  input  logic            we0,
  input  logic            we1,
  output logic            gnt0,
  output logic            gnt1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] s_addr,
  output logic [XLEN-1:0] s_wdata,
  output logic [XLEN-1:0] s_wmask,
  output logic            s_we,
  input  logic [XLEN-1:0] s_rdata
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  logic pick_last;
  logic pick0, pick1;
  logic keep0, keep1;

  // A locked owner keeps the port unless it drops its request or has used up its burst
  // while the other master waits; otherwise the owner is treated as the last winner.
  always_comb begin
    pick_last = last_q;
    keep0     = 1'b0;
    keep1     = 1'b0;
    case (state_q)
      ST_OWN0: begin
        pick_last = 1'b0;
        keep0     = req0 & ((cnt_q < CNT_MAX) | ~req1);
      end
      ST_OWN1: begin
        pick_last = 1'b1;
        keep1     = req1 & ((cnt_q < CNT_MAX) | ~req0);
      end
      default: ;
    endcase
  end

  rr_pick2 u_pick (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (pick_last),
    .gnt0_o (pick0),
    .gnt1_o (pick1)
  );

  assign gnt0 = reset & ~keep1 & (keep0 | pick0);
  assign gnt1 = reset & ~keep0 & (keep1 | pick1);

  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt0) begin
      last_d = 1'b0;
      if (lock0) begin
        state_d = ST_OWN0;
        cnt_d   = (state_q == ST_OWN0) ? cnt_inc : CW'(1);
      end
    end else if (gnt1) begin
      last_d = 1'b1;
      if (lock1) begin
        state_d = ST_OWN1;
        cnt_d   = (state_q == ST_OWN1) ? cnt_inc : CW'(1);
      end
    end
  end

  // last resets to 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = '0;
    s_we    = 1'b0;
    if (gnt0) begin
      s_addr  = addr0;
      s_wdata = wdata0;
      s_wmask = wmask0;
      s_we    = we0;
    end else if (gnt1) begin
      s_addr  = addr1;
      s_wdata = wdata1;
      s_wmask = wmask1;
      s_we    = we1;
    end
  end

  assign rdata0 = gnt0 ? s_rdata : '0;
  assign rdata1 = gnt1 ? s_rdata : '0;

endmodule
